// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controller and the multi-cycle execution ALU.
package alu_pkg;

  // ALU operation codes produced by the ALU controller
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_MUL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SLLV = 4'b1010;
  localparam logic [3:0] ALU_SRLV = 4'b1011;
  localparam logic [3:0] ALU_XOR  = 4'b1100;

  // Execution FSM: IDLE accepts new work, MUL waits on the iterative multiplier
  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/mul_iter.sv
// Radix-2 iterative shift-add multiplier producing the low DATA_W product bits.
// load_i starts a new product; done_o is high during the final iteration and
// result_o then carries the accumulator value including that last add.
module mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);
  import alu_pkg::*;

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              active_q, active_d;
  logic [DATA_W-1:0] acc_sum;

  // One shift-add step per cycle while active; a load restarts from a clean accumulator
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (load_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == LAST) begin
        cnt_d    = '0;
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Multiplier state registers; reset aborts any product in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done_o   = active_q && (cnt_q == LAST);
  assign result_o = acc_sum;

endmodule

// File: rtl/alu_multicycle.sv
// Execution-stage ALU: single-cycle ops finish one cycle after issue, MUL runs
// DATA_W iterations in mul_iter while busy_o stalls the datapath.
module alu_multicycle #(
  parameter int DATA_W = 32,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [SH_W-1:0]   shamt_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              illegal_o
);
  import alu_pkg::*;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              illegal_q, illegal_d;

  logic [DATA_W-1:0] alu_res;
  logic              alu_illegal;
  logic              mul_load;
  logic              mul_done;
  logic [DATA_W-1:0] mul_result;

  mul_iter #(.DATA_W(DATA_W)) u_mul_iter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (mul_load),
    .a_i      (src1_i),
    .b_i      (src2_i),
    .done_o   (mul_done),
    .result_o (mul_result)
  );

  // Single-cycle operations; unused codes yield zero and flag illegal
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (ctrl_i)
      ALU_AND:  alu_res = src1_i & src2_i;
      ALU_OR:   alu_res = src1_i | src2_i;
      ALU_XOR:  alu_res = src1_i ^ src2_i;
      ALU_ADD:  alu_res = src1_i + src2_i;
      ALU_SUB:  alu_res = src1_i - src2_i;
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      ALU_SLL:  alu_res = src2_i << shamt_i;
      ALU_SRL:  alu_res = src2_i >> shamt_i;
      ALU_SLLV: alu_res = src2_i << src1_i[SH_W-1:0];
      ALU_SRLV: alu_res = src2_i >> src1_i[SH_W-1:0];
      ALU_MUL:  alu_res = '0;
      default:  alu_illegal = 1'b1;
    endcase
  end

  // FSM next state: issue from IDLE, retire the multiply when mul_iter finishes
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    illegal_d = illegal_q;
    mul_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (ctrl_i == ALU_MUL) begin
            mul_load = 1'b1;
            busy_d   = 1'b1;
            state_d  = MUL;
          end else begin
            result_d  = alu_res;
            illegal_d = alu_illegal;
            done_d    = 1'b1;
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          result_d  = mul_result;
          illegal_d = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered outputs; reset drops any request in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      result_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      illegal_q <= illegal_d;
    end
  end

  assign result_o  = result_q;
  assign zero_o    = (result_q == '0);
  assign done_o    = done_q;
  assign busy_o    = busy_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: expected results are queued at issue
// and retired by a monitor whenever done_o is seen.
module tb_alu_multicycle;

  typedef struct packed {
    logic        illegal;
    logic [31:0] result;
  } exp_t;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp_res;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  ctrl_i = 4'b0;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic [4:0]  shamt_i = '0;
  logic [31:0] result_o;
  logic        zero_o;
  logic        done_o;
  logic        busy_o;
  logic        illegal_o;

  int   compared = 0;
  int   mismatched = 0;
  exp_t sb_q[$];

  alu_multicycle #(.DATA_W(32), .SH_W(5)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .ctrl_i    (ctrl_i),
    .src1_i    (src1_i),
    .src2_i    (src2_i),
    .shamt_i   (shamt_i),
    .result_o  (result_o),
    .zero_o    (zero_o),
    .done_o    (done_o),
    .busy_o    (busy_o),
    .illegal_o (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference behaviour for randomised operands
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh);
    exp_t e;
    e.illegal = 1'b0;
    e.result  = '0;
    case (c)
      4'b0000: e.result = a & b;
      4'b0001: e.result = a | b;
      4'b0010: e.result = a + b;
      4'b0011: e.result = 32'(a * b);
      4'b0110: e.result = a - b;
      4'b0111: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: e.result = b << sh;
      4'b1001: e.result = b >> sh;
      4'b1010: e.result = b << a[4:0];
      4'b1011: e.result = b >> a[4:0];
      4'b1100: e.result = a ^ b;
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  // Retire one scoreboard entry for every done_o pulse
  always @(negedge clk_i) begin
    if (done_o) begin
      compared++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_done: got result=%h with no pending op", result_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (result_o !== e.result || illegal_o !== e.illegal || zero_o !== (e.result == 32'd0)) begin
          mismatched++;
          $display("[TB] FAIL done_result: got res=%h ill=%b zero=%b, want res=%h ill=%b zero=%b",
                   result_o, illegal_o, zero_o, e.result, e.illegal, (e.result == 32'd0));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one issue at the current negedge and optionally queue its expectation
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] er, input logic ei,
                       input bit push);
    exp_t e;
    start_i = 1'b1;
    ctrl_i  = c;
    src1_i  = a;
    src2_i  = b;
    shamt_i = sh;
    e.result  = er;
    e.illegal = ei;
    if (push) sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    compared++;
    if (result_o !== 32'd0 || zero_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0 || illegal_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got res=%h zero=%b done=%b busy=%b ill=%b, want 0 1 0 0 0",
               result_o, zero_o, done_o, busy_o, illegal_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_single_cycle();
    vec_t v[$];
    v.push_back('{4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000});
    v.push_back('{4'b0110, 32'd5,        32'd5,        5'd0,  32'h00000000});
    v.push_back('{4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001});
    v.push_back('{4'b0111, 32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000});
    v.push_back('{4'b1011, 32'h00000024, 32'h80000000, 5'd0,  32'h08000000});
    v.push_back('{4'b1010, 32'h00000021, 32'h00000003, 5'd0,  32'h00000006});
    v.push_back('{4'b1000, 32'h0,        32'h00000001, 5'd31, 32'h80000000});
    v.push_back('{4'b1001, 32'h0,        32'hF0000000, 5'd4,  32'h0F000000});
    v.push_back('{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000});
    v.push_back('{4'b0001, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0,  32'hFFFFFFFF});
    v.push_back('{4'b1100, 32'hAAAAAAAA, 32'hFFFFFFFF, 5'd0,  32'h55555555});
    // back-to-back issue: one new op every cycle
    for (int i = 0; i < v.size(); i++) begin
      issue(v[i].ctrl, v[i].a, v[i].b, v[i].sh, v[i].exp_res, 1'b0, 1'b1);
      @(negedge clk_i);
      compared++;
      if (done_o !== 1'b1 || busy_o !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL single_done[%0d]: got done=%b busy=%b, want 1 0", i, done_o, busy_o);
      end
    end
    start_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_random_ops();
    logic [3:0] codes [11];
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000,
              4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b0011};
    for (int i = 0; i < 16; i++) begin
      logic [3:0]  c;
      logic [31:0] a, b;
      logic [4:0]  sh;
      exp_t        e;
      c  = codes[$urandom_range(0, 10)];
      a  = $urandom;
      b  = $urandom;
      sh = 5'($urandom_range(0, 31));
      e  = model(c, a, b, sh);
      issue(c, a, b, sh, e.result, e.illegal, 1'b1);
      @(negedge clk_i);
      start_i = 1'b0;
      if (c == 4'b0011) repeat (33) @(negedge clk_i);
    end
    @(negedge clk_i);
  endtask

  task automatic test_mul_stall();
    issue(4'b0011, 32'd7, 32'hFFFFFFFD, 5'd0, 32'hFFFFFFEB, 1'b0, 1'b1);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk_i);
      if (c == 1 || c == 11) start_i = 1'b0;
      if (c <= 33) begin
        compared++;
        if (busy_o !== (c <= 32) || done_o !== (c == 33)) begin
          mismatched++;
          $display("[TB] FAIL mul_timing[c%0d]: got busy=%b done=%b, want %b %b",
                   c, busy_o, done_o, (c <= 32), (c == 33));
        end
      end
      if (c == 10) issue(4'b0010, 32'd1, 32'd2, 5'd0, 32'd0, 1'b0, 1'b0);
      if (c == 33) issue(4'b0001, 32'h12340000, 32'h00005678, 5'd0, 32'h12345678, 1'b0, 1'b1);
      if (c == 34) begin
        compared++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL back_to_back: got done=%b busy=%b, want 1 0", done_o, busy_o);
        end
        start_i = 1'b0;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic test_illegal();
    logic [3:0] bad [5];
    bad = '{4'b0101, 4'b0100, 4'b1101, 4'b1110, 4'b1111};
    for (int i = 0; i < 5; i++) begin
      issue(bad[i], 32'hDEADBEEF, 32'h12345678, 5'd3, 32'd0, 1'b1, 1'b1);
      @(negedge clk_i);
      start_i = 1'b0;
      compared++;
      if (done_o !== 1'b1 || illegal_o !== 1'b1 || result_o !== 32'd0) begin
        mismatched++;
        $display("[TB] FAIL illegal[%h]: got done=%b ill=%b res=%h, want 1 1 0",
                 bad[i], done_o, illegal_o, result_o);
      end
    end
    issue(4'b0010, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0, 1'b1);
    @(negedge clk_i);
    start_i = 1'b0;
    compared++;
    if (illegal_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL illegal_clear: got ill=%b, want 0", illegal_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_mul();
    issue(4'b0011, 32'h00001234, 32'h00005678, 5'd0, 32'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      if (c == 1) start_i = 1'b0;
    end
    rst_i = 1'b1;
    issue(4'b0010, 32'd1, 32'd1, 5'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    start_i = 1'b0;
    compared++;
    if (busy_o !== 1'b0 || result_o !== 32'd0 || zero_o !== 1'b1 || done_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_mul: got busy=%b res=%h zero=%b done=%b, want 0 0 1 0",
               busy_o, result_o, zero_o, done_o);
    end
    repeat (40) @(negedge clk_i);
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single_cycle();
    test_mul_stall();
    test_illegal();
    test_random_ops();
    test_reset_mid_mul();
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL pending_ops: got %0d outstanding, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
